comma_align: RTL and testbench

Word aligner for the MII-over-VLC receive path. Takes unaligned 10-bit parallel words from the deserializer and searches all ten bit offsets of a 20-bit sliding window for a K28.5 comma (plus or minus disparity, masked). It then locks onto the comma offset through a hunt/acquire/sync state machine and emits byte-aligned 10-bit code groups to the 8b/10b decoder.

---
 rtl/comma_align_pkg.sv | 23 ++
 rtl/comma_win_det.sv | 45 ++++
 rtl/comma_align.sv | 170 +++++++++++++++++
 tb/tb_comma_align.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comma_align_pkg.sv
// Shared constants, FSM state type and window helper for the comma aligner.
package comma_align_pkg;

  // Default K28.5 patterns, bit 0 is the first bit off the wire.
  localparam logic [9:0] P_COMMA_DEF  = 10'b0101111100;
  localparam logic [9:0] M_COMMA_DEF  = 10'b1010000011;
  localparam logic [9:0] COM_MASK_DEF = 10'b1111111111;

  // Alignment state machine.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } align_state_e;

  // Ten-bit candidate taken from the 20-bit window starting at bit k.
  function automatic logic [9:0] win_slice(input logic [19:0] win, input logic [3:0] k);
    logic [19:0] sh;
    sh = win >> k;
    return sh[9:0];
  endfunction

endpackage

// File: rtl/comma_win_det.sv
// Combinational comma search over all ten offsets of a 20-bit window,
// with a lowest-offset-wins priority encoder.
module comma_win_det
  import comma_align_pkg::*;
(
  input  logic [19:0] i_win,
  input  logic [9:0]  i_p_comma,
  input  logic [9:0]  i_m_comma,
  input  logic [9:0]  i_mask,
  input  logic        i_p_en,
  input  logic        i_m_en,
  output logic [9:0]  o_hit,
  output logic        o_hit_any,
  output logic [3:0]  o_det_k
);

  logic [9:0] p_ref;
  logic [9:0] m_ref;

  assign p_ref = i_p_comma & i_mask;
  assign m_ref = i_m_comma & i_mask;

  // One comparator pair per bit offset.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_cand
      logic [9:0] cand;
      assign cand      = i_win[gi+9:gi] & i_mask;
      assign o_hit[gi] = (i_p_en && (cand == p_ref)) || (i_m_en && (cand == m_ref));
    end
  endgenerate

  assign o_hit_any = |o_hit;

  // Lowest hit offset wins; scanning downward lets the lowest index land last.
  always_comb begin
    o_det_k = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (o_hit[i]) begin
        o_det_k = 4'(i);
      end
    end
  end

endmodule

// File: rtl/comma_align.sv
// Word aligner: finds a K28.5 comma in the sliding window, locks onto its
// offset via HUNT/ACQ/SYNC and emits aligned 10-bit code groups one cycle later.
module comma_align
  import comma_align_pkg::*;
#(
  parameter logic [9:0] P_COMMA  = P_COMMA_DEF,
  parameter logic [9:0] M_COMMA  = M_COMMA_DEF,
  parameter logic [9:0] COM_MASK = COM_MASK_DEF,
  parameter int         LOCK_CNT = 3,
  parameter int         LOSS_CNT = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [9:0] i_Data,
  input  logic       i_Valid,
  input  logic       i_PComAlignEn,
  input  logic       i_MComAlignEn,
  input  logic       i_ReAlign,
  output logic [9:0] o_Data,
  output logic       o_Valid,
  output logic       o_ComDet,
  output logic [3:0] o_Offset,
  output logic       o_Aligned,
  output logic       o_Realigned
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam int ERR_W = $clog2(LOSS_CNT + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] LOSS_MAX = ERR_W'(LOSS_CNT);

  align_state_e     state_q, state_d;
  logic [9:0]       prev_q, prev_d;
  logic [3:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [9:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             comdet_q, comdet_d;
  logic             realigned_q, realigned_d;

  logic [19:0] win;
  logic [9:0]  hit_vec;
  logic        hit_any;
  logic [3:0]  det_k;
  logic        hit_own;
  logic        use_det;
  logic [3:0]  eff_off;

  assign win = {i_Data, prev_q};

  comma_win_det u_det (
    .i_win     (win),
    .i_p_comma (P_COMMA),
    .i_m_comma (M_COMMA),
    .i_mask    (COM_MASK),
    .i_p_en    (i_PComAlignEn),
    .i_m_en    (i_MComAlignEn),
    .o_hit     (hit_vec),
    .o_hit_any (hit_any),
    .o_det_k   (det_k)
  );

  // Pick the offset for this word: a fresh detection in HUNT, or a foreign
  // comma while still acquiring, overrides the latched offset.
  always_comb begin
    hit_own = hit_vec[off_q];
    use_det = hit_any && ((state_q == HUNT) || ((state_q == ACQ) && !hit_own));
    eff_off = use_det ? det_k : off_q;
  end

  // State register and output registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      comdet_q    <= 1'b0;
      realigned_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      comdet_q    <= comdet_d;
      realigned_q <= realigned_d;
    end
  end

  // Next-state logic: lock/loss counting on valid words, realign overrides all.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (i_Valid) begin
      prev_d = i_Data;
      off_d  = eff_off;
      case (state_q)
        HUNT: begin
          if (hit_any) begin
            cnt_d   = CNT_W'(1);
            state_d = (LOCK_CNT == 1) ? SYNC : ACQ;
          end
        end
        ACQ: begin
          if (hit_own) begin
            if (cnt_q >= LOCK_MAX - 1'b1) begin
              cnt_d   = LOCK_MAX;
              state_d = SYNC;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (hit_any) begin
            cnt_d = CNT_W'(1);
          end
        end
        SYNC: begin
          if (hit_own) begin
            err_d = '0;
          end else if (hit_any) begin
            if (err_q >= LOSS_MAX - 1'b1) begin
              state_d = HUNT;
              err_d   = '0;
              cnt_d   = '0;
            end else begin
              err_d = err_q + 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (i_ReAlign) begin
      state_d = HUNT;
      cnt_d   = '0;
      err_d   = '0;
      off_d   = off_q;
    end
  end

  // Output word selection: aligned slice, comma flag and offset-change pulse.
  always_comb begin
    data_d      = data_q;
    valid_d     = i_Valid;
    comdet_d    = 1'b0;
    realigned_d = 1'b0;
    if (i_Valid) begin
      data_d      = win_slice(win, eff_off);
      comdet_d    = hit_vec[eff_off];
      realigned_d = (off_d != off_q);
    end
  end

  assign o_Data      = data_q;
  assign o_Valid     = valid_q;
  assign o_ComDet    = comdet_q;
  assign o_Offset    = off_q;
  assign o_Aligned   = (state_q == SYNC);
  assign o_Realigned = realigned_q;

endmodule

// File: tb/tb_comma_align.sv
// Randomized bench for comma_align: a bit-stream generator places commas at
// chosen bit offsets, and a word-level reference model predicts every output.
module tb_comma_align;

  localparam logic [9:0] P_C = 10'b0101111100;
  localparam logic [9:0] M_C = 10'b1010000011;
  localparam int LOCK = 3;
  localparam int LOSS = 4;
  localparam int ST_HUNT = 0;
  localparam int ST_ACQ  = 1;
  localparam int ST_SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       vin = 1'b0;
  logic       pen = 1'b1;
  logic       men = 1'b1;
  logic       realign = 1'b0;
  logic [9:0] dout;
  logic       vout, comdet, aligned, realigned;
  logic [3:0] offset;

  logic [9:0] d2_in = '0;
  logic       d2_vin = 1'b0;
  logic [9:0] d2_out;
  logic       d2_vout, d2_com, d2_al, d2_re;
  logic [3:0] d2_off;

  int num_checks = 0;
  int num_errors = 0;
  int tx_count = 0;

  // Reference model state
  logic [9:0] m_prev = '0;
  int m_state = ST_HUNT;
  int m_off = 0;
  int m_cnt = 0;
  int m_err = 0;
  logic [9:0] e_data = '0;
  bit e_valid = 0, e_com = 0, e_realigned = 0, e_chk_data = 1;

  // Bit-stream generator state
  bit bq[$];
  bit last_b = 0;
  int run_len = 0;

  bit saw_realign = 0, saw_comdet = 0;
  logic [9:0] last_com_data = '0;
  int last_com_off = -1;

  always #5 clk = ~clk;

  comma_align #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Data(din), .i_Valid(vin),
    .i_PComAlignEn(pen), .i_MComAlignEn(men), .i_ReAlign(realign),
    .o_Data(dout), .o_Valid(vout), .o_ComDet(comdet), .o_Offset(offset),
    .o_Aligned(aligned), .o_Realigned(realigned)
  );

  comma_align #(.COM_MASK(10'b0001111111), .LOCK_CNT(1), .LOSS_CNT(1)) dut_mask (
    .i_Clk(clk), .i_Rst(rst), .i_Data(d2_in), .i_Valid(d2_vin),
    .i_PComAlignEn(1'b1), .i_MComAlignEn(1'b0), .i_ReAlign(1'b0),
    .o_Data(d2_out), .o_Valid(d2_vout), .o_ComDet(d2_com), .o_Offset(d2_off),
    .o_Aligned(d2_al), .o_Realigned(d2_re)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model of one clock edge, from the alignment rules.
  task automatic model_step(input logic [9:0] d, input logic v, input logic ra, input logic r);
    logic [19:0] w;
    logic [9:0] c;
    bit hit[10];
    bit any, own;
    int det, eff;
    if (r) begin
      m_prev = '0; m_state = ST_HUNT; m_off = 0; m_cnt = 0; m_err = 0;
      e_data = '0; e_valid = 0; e_com = 0; e_realigned = 0; e_chk_data = 1;
      return;
    end
    e_valid = v; e_com = 0; e_realigned = 0; e_chk_data = 0;
    if (v) begin
      w = {d, m_prev};
      any = 0; det = -1;
      for (int k = 0; k < 10; k++) begin
        c = 10'(w >> k);
        hit[k] = (pen && c == P_C) || (men && c == M_C);
        if (hit[k] && det < 0) det = k;
        any = any | hit[k];
      end
      own = hit[m_off];
      if ((m_state == ST_HUNT && any) || (m_state == ST_ACQ && any && !own)) eff = det;
      else eff = m_off;
      e_data = 10'(w >> eff);
      e_com = hit[eff];
      e_chk_data = !(m_state == ST_HUNT && !any);
      e_realigned = !ra && (eff != m_off);
      if (!ra) begin
        if (m_state == ST_HUNT) begin
          if (any) begin m_cnt = 1; m_state = (LOCK == 1) ? ST_SYNC : ST_ACQ; end
        end else if (m_state == ST_ACQ) begin
          if (own) begin m_cnt++; if (m_cnt >= LOCK) m_state = ST_SYNC; end
          else if (any) m_cnt = 1;
        end else begin
          if (own) m_err = 0;
          else if (any) begin
            m_err++;
            if (m_err >= LOSS) begin m_state = ST_HUNT; m_err = 0; m_cnt = 0; end
          end
        end
        m_off = eff;
      end
      m_prev = d;
    end
    if (ra) begin m_state = ST_HUNT; m_cnt = 0; m_err = 0; end
  endtask

  // One clock: drive, let the edge happen, compare 1 ns later.
  task automatic drive(input logic [9:0] d, input logic v, input logic ra, input logic r);
    din = d; vin = v; realign = ra; rst = r;
    @(posedge clk);
    model_step(d, v, ra, r);
    #1;
    chk("valid", vout, e_valid);
    if (e_valid) begin
      if (e_chk_data) chk("data", dout, e_data);
      chk("comdet", comdet, e_com);
      chk("realigned", realigned, e_realigned);
      if (realigned) saw_realign = 1;
      if (comdet) begin saw_comdet = 1; last_com_data = dout; last_com_off = offset; end
    end
    chk("offset", offset, m_off);
    chk("aligned", aligned, m_state == ST_SYNC);
    tx_count++;
    $display("tx %0d in=%h v=%b ra=%b rst=%b pe=%b me=%b | out=%h v=%b com=%b off=%0d al=%b re=%b",
             tx_count, d, v, ra, r, pen, men, dout, vout, comdet, offset, aligned, realigned);
  endtask

  task automatic push_bit(input bit b);
    bq.push_back(b);
    if (b == last_b) run_len++;
    else begin run_len = 1; last_b = b; end
  endtask

  // Filler never has a run of three, so it cannot contain or fake a comma.
  task automatic push_filler();
    bit b;
    b = 1'($urandom);
    if (run_len >= 2 && b == last_b) b = !b;
    push_bit(b);
  endtask

  // nw words; a comma starts at bit 'off' of every 'every'-th word.
  task automatic add_seg(input int nw, input int every, input int off, input bit use_m);
    int pos;
    logic [9:0] pat;
    pat = use_m ? M_C : P_C;
    pos = 0;
    while (pos < nw * 10) begin
      if ((pos % 10) == off && ((pos / 10) % every) == 0 && pos + 10 <= nw * 10) begin
        for (int i = 0; i < 10; i++) push_bit(pat[i]);
        pos += 10;
      end else begin
        push_filler();
        pos++;
      end
    end
  endtask

  task automatic send_words(input bit gaps, input bit jitter_en);
    logic [9:0] w;
    while (bq.size() >= 10) begin
      for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
      if (jitter_en && $urandom_range(9) == 0) begin
        pen = 1'($urandom); men = 1'($urandom);
      end
      if (gaps) drive(10'($urandom), 1'b0, 1'b0, 1'b0);
      drive(w, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset
    drive(10'h3FF, 1'b1, 1'b0, 1'b1);
    drive(10'h155, 1'b0, 1'b0, 1'b1);
    chk("rst_data", dout, 10'd0);
    chk("rst_valid", vout, 1'b0);
    chk("rst_comdet", comdet, 1'b0);
    chk("rst_offset", offset, 4'd0);
    chk("rst_aligned", aligned, 1'b0);
    chk("rst_realigned", realigned, 1'b0);

    // Masked compare: bit 8 corrupted, still detected at offset 0
    d2_in = P_C ^ 10'b0100000000; d2_vin = 1'b1;
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    chk("mask_pre_com", d2_com, 1'b0);
    d2_in = 10'd0;
    drive(10'd0, 1'b0, 1'b0, 1'b0);
    d2_vin = 1'b0;
    chk("mask_valid", d2_vout, 1'b1);
    chk("mask_com", d2_com, 1'b1);
    chk("mask_data", d2_out, P_C ^ 10'b0100000000);
    chk("mask_off", d2_off, 4'd0);
    chk("mask_aligned", d2_al, 1'b1);

    // Lock at offset 3
    add_seg(16, 4, 3, 1'b0);
    send_words(1'b0, 1'b0);
    chk("lock_aligned", aligned, 1'b1);
    chk("lock_off", offset, 4'd3);

    // Loss of lock to offset 6, then re-detect in HUNT
    add_seg(16, 4, 6, 1'b0);
    send_words(1'b0, 1'b0);
    chk("loss_aligned", aligned, 1'b0);
    saw_realign = 0;
    add_seg(4, 4, 6, 1'b0);
    send_words(1'b0, 1'b0);
    chk("loss_off", offset, 4'd6);
    chk("loss_realign_pulse", saw_realign, 1'b1);

    // Offset 0 and offset 9 edges
    drive(10'd0, 1'b0, 1'b1, 1'b0);
    add_seg(4, 4, 0, 1'b0);
    send_words(1'b0, 1'b0);
    chk("k0_data", last_com_data, P_C);
    chk("k0_off", last_com_off, 0);
    drive(10'd0, 1'b0, 1'b1, 1'b0);
    add_seg(4, 4, 9, 1'b0);
    send_words(1'b0, 1'b0);
    chk("k9_data", last_com_data, P_C);
    chk("k9_off", last_com_off, 9);

    // Alternating foreign/matching commas while in SYNC
    drive(10'd0, 1'b0, 1'b1, 1'b0);
    add_seg(16, 4, 3, 1'b0);
    send_words(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      add_seg(2, 2, 6, 1'b0);
      add_seg(2, 2, 3, 1'b0);
      send_words(1'b0, 1'b0);
      chk("err_aligned", aligned, 1'b1);
    end

    // M commas with M enable low: no lock, no detection
    drive(10'd0, 1'b0, 1'b1, 1'b0);
    men = 1'b0;
    saw_comdet = 0;
    add_seg(16, 4, 5, 1'b1);
    send_words(1'b0, 1'b0);
    chk("men_off_aligned", aligned, 1'b0);
    chk("men_off_comdet", saw_comdet, 1'b0);
    men = 1'b1;
    add_seg(16, 4, 5, 1'b1);
    send_words(1'b0, 1'b0);
    chk("men_on_aligned", aligned, 1'b1);
    chk("men_on_off", offset, 4'd5);

    // Valid gaps hold state; realign in SYNC drops o_Aligned next cycle
    add_seg(8, 4, 5, 1'b1);
    send_words(1'b1, 1'b0);
    chk("gap_aligned", aligned, 1'b1);
    drive(10'd0, 1'b0, 1'b1, 1'b0);
    chk("realign_aligned", aligned, 1'b0);
    chk("realign_off_kept", offset, 4'd5);

    // Randomized segments
    for (int s = 0; s < 40; s++) begin
      int r;
      r = $urandom_range(19);
      if (r == 0) drive(10'($urandom), 1'($urandom), 1'b0, 1'b1);
      else if (r < 3) drive(10'($urandom), 1'b0, 1'b1, 1'b0);
      pen = ($urandom_range(3) != 0);
      men = ($urandom_range(3) != 0);
      add_seg($urandom_range(8, 2), $urandom_range(4, 2), $urandom_range(9, 0), 1'($urandom));
      send_words($urandom_range(3) == 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
